// File: rtl/op_pkg.sv
// -----------------------------------------------------------------------------
// op_pkg
// Definitions shared by the front-panel operation sequencer and the datapath:
// opcode encodings, error codes, the sequencer state encoding and the one-hot
// switch decode.
// -----------------------------------------------------------------------------
package op_pkg;

    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_1    = 3'b001;
    localparam logic [2:0] OP_2    = 3'b010;
    localparam logic [2:0] OP_3    = 3'b011;
    localparam logic [2:0] OP_4    = 3'b100;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_INVALID = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_FAULT   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    // Exactly one switch up selects an opcode; anything else (all down,
    // several up) decodes to OP_NONE, which marks the pattern invalid.
    function automatic logic [2:0] onehot_to_opcode(input logic [3:0] sw);
        logic [2:0] op;
        case (sw)
            4'b1000: op = OP_1;
            4'b0100: op = OP_2;
            4'b0010: op = OP_3;
            4'b0001: op = OP_4;
            default: op = OP_NONE;
        endcase
        return op;
    endfunction

    function automatic logic opcode_valid(input logic [2:0] op);
        return (op != OP_NONE);
    endfunction

endpackage

// File: rtl/op_sequencer_key_edge.sv
// -----------------------------------------------------------------------------
// key_edge
// Synchronizes the asynchronous active-low start key into clk and produces a
// single-cycle press pulse on each released->pressed transition.
//
// Ports
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   key_n_i  in   raw pushbutton, active-low, asynchronous to clk
//   press_o  out  1-cycle pulse on the synchronized 1->0 edge
// -----------------------------------------------------------------------------
module key_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n_i,
    output logic press_o
);

    logic       sync1_q;
    logic       sync2_q;
    logic       prev_q;
    logic       armed_q;
    logic [1:0] fill_q;

    // The synchronizer flops come out of reset reading "released", which would
    // look like a falling edge if the key is already held when reset lifts.
    // fill_q marks when sync2_q holds a genuine sample of the pin; the detector
    // only arms after it has seen a genuinely released key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            armed_q <= 1'b0;
            fill_q  <= 2'b00;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            fill_q  <= {fill_q[0], 1'b1};
            if (fill_q[1] && sync2_q) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign press_o = armed_q & prev_q & ~sync2_q;

endmodule

// File: rtl/op_sequencer.sv
// -----------------------------------------------------------------------------
// op_sequencer
// Front-panel operation controller. A start-key press decodes the one-hot
// switch bank into an opcode and issues a single dp_start strobe, then waits
// for the datapath's done/error answer under a timeout and holds the outcome
// on the status outputs until the next press.
//
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   sw[3:0]      in   one-hot switch bank, sampled on a press
//   key_start_n  in   start pushbutton, active-low, asynchronous
//   dp_done      in   datapath completion pulse
//   dp_error     in   datapath fault pulse
//   dp_start     out  1-cycle command strobe
//   dp_opcode    out  opcode latched for the current/last operation
//   busy         out  operation in flight (ISSUE, WAIT)
//   done_led     out  last operation completed (DONE)
//   err_led      out  error held (ERROR)
//   err_code     out  00 none, 01 invalid switches, 10 timeout, 11 fault
//   op_count     out  completed-operation count, wraps at 256
//
// state | meaning
// IDLE  | waiting for a press, nothing held
// ISSUE | dp_start high for one cycle, timeout counter cleared
// WAIT  | waiting for dp_done/dp_error, timeout counter running
// DONE  | last operation completed, done_led held
// ERROR | error held until a press, which only clears it
// -----------------------------------------------------------------------------
module op_sequencer
    import op_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw,
    input  logic       key_start_n,
    input  logic       dp_done,
    input  logic       dp_error,
    output logic       dp_start,
    output logic [2:0] dp_opcode,
    output logic       busy,
    output logic       done_led,
    output logic       err_led,
    output logic [1:0] err_code,
    output logic [7:0] op_count
);

    localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic             press;
    logic [2:0]       sw_op_d;
    logic             sw_ok_d;

    state_t           state_q;
    logic             dp_start_q;
    logic [2:0]       opcode_q;
    logic             busy_q;
    logic             done_led_q;
    logic             err_led_q;
    logic [1:0]       err_code_q;
    logic [7:0]       op_count_q;
    logic [CNT_W-1:0] cnt_q;

    key_edge u_key_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_n_i (key_start_n),
        .press_o (press)
    );

    assign sw_op_d = onehot_to_opcode(sw);
    assign sw_ok_d = opcode_valid(sw_op_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            dp_start_q <= 1'b0;
            opcode_q   <= OP_NONE;
            busy_q     <= 1'b0;
            done_led_q <= 1'b0;
            err_led_q  <= 1'b0;
            err_code_q <= ERR_NONE;
            op_count_q <= 8'd0;
            cnt_q      <= '0;
        end else begin
            dp_start_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (press) begin
                        done_led_q <= 1'b0;
                        if (sw_ok_d) begin
                            opcode_q   <= sw_op_d;
                            dp_start_q <= 1'b1;
                            busy_q     <= 1'b1;
                            state_q    <= ST_ISSUE;
                        end else begin
                            err_led_q  <= 1'b1;
                            err_code_q <= ERR_INVALID;
                            state_q    <= ST_ERROR;
                        end
                    end
                end
                ST_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Fault beats completion; completion beats the timeout.
                    if (dp_error) begin
                        busy_q     <= 1'b0;
                        err_led_q  <= 1'b1;
                        err_code_q <= ERR_FAULT;
                        state_q    <= ST_ERROR;
                    end else if (dp_done) begin
                        busy_q     <= 1'b0;
                        done_led_q <= 1'b1;
                        op_count_q <= op_count_q + 8'd1;
                        state_q    <= ST_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        busy_q     <= 1'b0;
                        err_led_q  <= 1'b1;
                        err_code_q <= ERR_TIMEOUT;
                        state_q    <= ST_ERROR;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_ERROR: begin
                    if (press) begin
                        err_led_q  <= 1'b0;
                        err_code_q <= ERR_NONE;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign dp_start  = dp_start_q;
    assign dp_opcode = opcode_q;
    assign busy      = busy_q;
    assign done_led  = done_led_q;
    assign err_led   = err_led_q;
    assign err_code  = err_code_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_op_sequencer.sv
module tb_op_sequencer;

    localparam int T = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sw = 4'b0000;
    logic       key_start_n = 1'b1;
    logic       dp_done = 1'b0;
    logic       dp_error = 1'b0;
    logic       dp_start;
    logic [2:0] dp_opcode;
    logic       busy;
    logic       done_led;
    logic       err_led;
    logic [1:0] err_code;
    logic [7:0] op_count;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       err;
        logic [1:0] code;
        logic [7:0] cnt;
    } res_t;

    int         tests = 0;
    int         fails = 0;
    int         start_cnt = 0;
    logic [7:0] exp_ops = 8'd0;
    logic [2:0] op_q[$];
    res_t       res_q[$];

    op_sequencer #(.TIMEOUT_CYCLES(T)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sw          (sw),
        .key_start_n (key_start_n),
        .dp_done     (dp_done),
        .dp_error    (dp_error),
        .dp_start    (dp_start),
        .dp_opcode   (dp_opcode),
        .busy        (busy),
        .done_led    (done_led),
        .err_led     (err_led),
        .err_code    (err_code),
        .op_count    (op_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dp_start === 1'b1) start_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [2:0] tb_decode(input logic [3:0] s);
        logic [2:0] r;
        r = 3'b000;
        if (s == 4'b1000) r = 3'b001;
        if (s == 4'b0100) r = 3'b010;
        if (s == 4'b0010) r = 3'b011;
        if (s == 4'b0001) r = 3'b100;
        return r;
    endfunction

    function automatic res_t sample();
        res_t r;
        r = {busy, done_led, err_led, err_code, op_count};
        return r;
    endfunction

    // Hold the key down until dp_start is seen (bounded), then release it.
    task automatic start_op(input logic [3:0] s, output bit ok, output logic [2:0] op);
        sw = s;
        op_q.push_back(tb_decode(s));
        key_start_n = 1'b0;
        ok = 1'b0;
        op = 3'b000;
        for (int i = 0; i < 12 && !ok; i++) begin
            @(negedge clk);
            if (dp_start === 1'b1) begin
                ok = 1'b1;
                op = dp_opcode;
            end
        end
        key_start_n = 1'b1;
    endtask

    // Pulse responses in WAIT cycle w (counted from the dp_start negedge).
    task automatic respond(input int w, input bit d, input bit e);
        repeat (w) @(negedge clk);
        dp_done  = d;
        dp_error = e;
        @(negedge clk);
        dp_done  = 1'b0;
        dp_error = 1'b0;
    endtask

    task automatic tap_key();
        key_start_n = 1'b0;
        repeat (6) @(negedge clk);
        key_start_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        res_t r, e;
        #1;
        tests++;
        if ({dp_start, dp_opcode} !== 4'b0) begin
            fails++;
            $display("FAIL reset_cmd: got %b required 0000", {dp_start, dp_opcode});
        end
        e = '0;
        r = sample();
        tests++;
        if (r !== e) begin
            fails++;
            $display("FAIL reset_status: got %h required %h", r, e);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        r = sample();
        tests++;
        if (r !== e || dp_start !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: got %h/%b required %h/0", r, dp_start, e);
        end
    endtask

    task automatic test_normal();
        bit ok;
        logic [2:0] op, exp_op;
        int sc0;
        res_t e, r;
        sc0 = start_cnt;
        start_op(4'b0100, ok, op);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL normal_start: got no dp_start required one");
        end
        exp_op = op_q.pop_front();
        tests++;
        if (op !== exp_op) begin
            fails++;
            $display("FAIL normal_opcode: got %b required %b", op, exp_op);
        end
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL normal_busy_issue: got %b required 1", busy);
        end
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            tests++;
            if (busy !== 1'b1 || dp_start !== 1'b0) begin
                fails++;
                $display("FAIL normal_wait%0d: got busy=%b start=%b required 1/0", i, busy, dp_start);
            end
        end
        dp_done = 1'b1;
        @(negedge clk);
        dp_done = 1'b0;
        exp_ops = exp_ops + 8'd1;
        res_q.push_back({1'b0, 1'b1, 1'b0, 2'b00, exp_ops});
        e = res_q.pop_front();
        r = sample();
        tests++;
        if (r !== e) begin
            fails++;
            $display("FAIL normal_done: got %h required %h", r, e);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (start_cnt - sc0 !== 1 || dp_opcode !== 3'b010) begin
            fails++;
            $display("FAIL normal_single: got %0d starts op %b required 1 starts op 010",
                     start_cnt - sc0, dp_opcode);
        end
    endtask

    task automatic test_invalid();
        bit ok;
        logic [2:0] op, exp_op;
        int sc0;
        res_t e, r;
        sc0 = start_cnt;
        sw = 4'b0110;
        tap_key();
        res_q.push_back({1'b0, 1'b0, 1'b1, 2'b01, exp_ops});
        e = res_q.pop_front();
        r = sample();
        tests++;
        if (r !== e || start_cnt != sc0) begin
            fails++;
            $display("FAIL invalid_err: got %h starts=%0d required %h starts=0", r, start_cnt - sc0, e);
        end
        tests++;
        if (dp_opcode !== 3'b010) begin
            fails++;
            $display("FAIL invalid_opcode_hold: got %b required 010", dp_opcode);
        end
        tap_key();
        res_q.push_back({1'b0, 1'b0, 1'b0, 2'b00, exp_ops});
        e = res_q.pop_front();
        r = sample();
        tests++;
        if (r !== e || start_cnt != sc0) begin
            fails++;
            $display("FAIL invalid_clear: got %h starts=%0d required %h starts=0", r, start_cnt - sc0, e);
        end
        start_op(4'b0001, ok, op);
        exp_op = op_q.pop_front();
        tests++;
        if (!ok || op !== exp_op) begin
            fails++;
            $display("FAIL invalid_third: got ok=%b op=%b required ok=1 op=%b", ok, op, exp_op);
        end
        respond(2, 1'b1, 1'b0);
        exp_ops = exp_ops + 8'd1;
        res_q.push_back({1'b0, 1'b1, 1'b0, 2'b00, exp_ops});
        e = res_q.pop_front();
        r = sample();
        tests++;
        if (r !== e) begin
            fails++;
            $display("FAIL invalid_third_done: got %h required %h", r, e);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_simultaneous();
        bit ok;
        logic [2:0] op, exp_op;
        int sc0;
        res_t e, r;
        start_op(4'b1000, ok, op);
        exp_op = op_q.pop_front();
        tests++;
        if (!ok || op !== exp_op) begin
            fails++;
            $display("FAIL simul_start: got ok=%b op=%b required ok=1 op=%b", ok, op, exp_op);
        end
        respond(3, 1'b1, 1'b1);
        res_q.push_back({1'b0, 1'b0, 1'b1, 2'b11, exp_ops});
        e = res_q.pop_front();
        r = sample();
        tests++;
        if (r !== e) begin
            fails++;
            $display("FAIL simul_fault: got %h required %h", r, e);
        end
        tap_key();
        sc0 = start_cnt;
        start_op(4'b0010, ok, op);
        exp_op = op_q.pop_front();
        tests++;
        if (!ok || op !== exp_op) begin
            fails++;
            $display("FAIL drop_start: got ok=%b op=%b required ok=1 op=%b", ok, op, exp_op);
        end
        repeat (3) @(negedge clk);
        key_start_n = 1'b0;
        repeat (5) @(negedge clk);
        key_start_n = 1'b1;
        respond(4, 1'b1, 1'b0);
        exp_ops = exp_ops + 8'd1;
        res_q.push_back({1'b0, 1'b1, 1'b0, 2'b00, exp_ops});
        e = res_q.pop_front();
        r = sample();
        tests++;
        if (r !== e) begin
            fails++;
            $display("FAIL drop_done: got %h required %h", r, e);
        end
        repeat (4) @(negedge clk);
        tests++;
        if (start_cnt - sc0 !== 1) begin
            fails++;
            $display("FAIL drop_press: got %0d starts required 1", start_cnt - sc0);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        logic [2:0] op, exp_op;
        res_t e, r;
        start_op(4'b0100, ok, op);
        exp_op = op_q.pop_front();
        tests++;
        if (!ok || op !== exp_op) begin
            fails++;
            $display("FAIL timeout_start: got ok=%b op=%b required ok=1 op=%b", ok, op, exp_op);
        end
        repeat (T) @(negedge clk);
        tests++;
        if (busy !== 1'b1 || err_led !== 1'b0) begin
            fails++;
            $display("FAIL timeout_early: got busy=%b err=%b required 1/0", busy, err_led);
        end
        @(negedge clk);
        res_q.push_back({1'b0, 1'b0, 1'b1, 2'b10, exp_ops});
        e = res_q.pop_front();
        r = sample();
        tests++;
        if (r !== e) begin
            fails++;
            $display("FAIL timeout_err: got %h required %h", r, e);
        end
        tap_key();
        start_op(4'b0001, ok, op);
        exp_op = op_q.pop_front();
        tests++;
        if (!ok || op !== exp_op) begin
            fails++;
            $display("FAIL timeout2_start: got ok=%b op=%b required ok=1 op=%b", ok, op, exp_op);
        end
        respond(T, 1'b1, 1'b0);
        exp_ops = exp_ops + 8'd1;
        res_q.push_back({1'b0, 1'b1, 1'b0, 2'b00, exp_ops});
        e = res_q.pop_front();
        r = sample();
        tests++;
        if (r !== e) begin
            fails++;
            $display("FAIL timeout_done_wins: got %h required %h", r, e);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [2:0] op, exp_op;
        logic [3:0] s;
        res_t e, r;
        for (int i = 0; i < 256; i++) begin
            s = 4'b1000 >> (i % 4);
            start_op(s, ok, op);
            exp_op = op_q.pop_front();
            tests++;
            if (!ok || op !== exp_op) begin
                fails++;
                $display("FAIL b2b_start%0d: got ok=%b op=%b required ok=1 op=%b", i, ok, op, exp_op);
            end
            respond(1, 1'b1, 1'b0);
            exp_ops = exp_ops + 8'd1;
            res_q.push_back({1'b0, 1'b1, 1'b0, 2'b00, exp_ops});
            e = res_q.pop_front();
            r = sample();
            tests++;
            if (r !== e) begin
                fails++;
                $display("FAIL b2b_count%0d: got %h required %h", i, r, e);
            end
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        logic [2:0] op, exp_op;
        int sc0;
        start_op(4'b0001, ok, op);
        exp_op = op_q.pop_front();
        tests++;
        if (!ok || op !== exp_op) begin
            fails++;
            $display("FAIL rst_start: got ok=%b op=%b required ok=1 op=%b", ok, op, exp_op);
        end
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        key_start_n = 1'b0;
        #1;
        tests++;
        if ({dp_start, busy, done_led, err_led, err_code, op_count, dp_opcode} !== 16'h0) begin
            fails++;
            $display("FAIL rst_async: got %h required 0000",
                     {dp_start, busy, done_led, err_led, err_code, op_count, dp_opcode});
        end
        exp_ops = 8'd0;
        op_q.delete();
        res_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        sc0 = start_cnt;
        repeat (30) @(negedge clk);
        tests++;
        if (start_cnt != sc0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_held_key: got %0d starts busy=%b required 0 starts busy=0",
                     start_cnt - sc0, busy);
        end
        key_start_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_idle_response();
        bit ok;
        logic [2:0] op, exp_op;
        res_t e, r;
        dp_done = 1'b1;
        @(negedge clk);
        dp_done = 1'b0;
        dp_error = 1'b1;
        @(negedge clk);
        dp_error = 1'b0;
        @(negedge clk);
        res_q.push_back({1'b0, 1'b0, 1'b0, 2'b00, exp_ops});
        e = res_q.pop_front();
        r = sample();
        tests++;
        if (r !== e) begin
            fails++;
            $display("FAIL idle_ignore: got %h required %h", r, e);
        end
        start_op(4'b0010, ok, op);
        exp_op = op_q.pop_front();
        tests++;
        if (!ok || op !== exp_op) begin
            fails++;
            $display("FAIL post_rst_start: got ok=%b op=%b required ok=1 op=%b", ok, op, exp_op);
        end
        respond(2, 1'b1, 1'b0);
        exp_ops = exp_ops + 8'd1;
        res_q.push_back({1'b0, 1'b1, 1'b0, 2'b00, exp_ops});
        e = res_q.pop_front();
        r = sample();
        tests++;
        if (r !== e) begin
            fails++;
            $display("FAIL post_rst_done: got %h required %h", r, e);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_invalid();
        test_simultaneous();
        test_timeout();
        test_back_to_back();
        test_reset_mid_wait();
        test_idle_response();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/op_sequencer.md
# op_sequencer

Front-panel operation controller between the switch/key inputs and the processing datapath. On a start-key press it decodes the one-hot switch bank into a 3-bit opcode and issues one start pulse. It then waits for the datapath's done/error response with a timeout and holds the result on status outputs until the next press. The block owns all sequencing; the datapath only sees a start/opcode command and answers with done or error.

## Interface
- `TIMEOUT_CYCLES`, default 1024: WAIT-state cycles before declaring timeout; legal range ≥ 2.
- `clk`  in  1  system clock; the block is single-clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `sw`  in  4  switch bank; quasi-static, sampled only on a press.
- `key_start_n`  in  1  start pushbutton, active-low, asynchronous to `clk`.
- `dp_done`  in  1  datapath completion, 1-cycle pulse.
- `dp_error`  in  1  datapath fault, 1-cycle pulse.
- `dp_start`  out  1  command strobe, exactly 1 cycle.
- `dp_opcode`  out  3  latched opcode, stable from ISSUE until the next accepted operation.
- `busy`  out  1  high in ISSUE and WAIT.
- `done_led`  out  1  high in DONE.
- `err_led`  out  1  high in ERROR.
- `err_code`  out  2  00 none, 01 invalid switch pattern, 10 timeout, 11 datapath fault.
- `op_count`  out  8  count of successfully completed operations.

## Operation
- **Key path:**
  - `key_start_n` passes through a 2-flop synchronizer; both flops reset to 1 (released).
  - `press` is a 1-cycle pulse on the 1→0 transition of the synchronized signal.
- **Switch decode:**
  - 1000→001, 0100→010, 0010→011, 0001→100.
  - Any other pattern, including 0000 and multi-hot, is invalid.
- **FSM states:** IDLE, ISSUE, WAIT, DONE, ERROR.
- **IDLE or DONE, on `press`:**
  - Valid `sw`: latch the opcode into `dp_opcode`, clear `done_led`, go to ISSUE.
  - Invalid `sw`: `err_code`=01, go to ERROR, no `dp_start`.
- **ISSUE:** `dp_start`=1 for this single cycle, timeout counter cleared, go to WAIT unconditionally.
- **WAIT:** the counter increments each cycle. Exits, in priority order:
  - `dp_error` → ERROR, `err_code`=11.
  - `dp_done` → DONE, `op_count`+1.
  - Counter reaches `TIMEOUT_CYCLES`-1 with neither response → ERROR, `err_code`=10.
- **Simultaneous events:**
  - `dp_error` with `dp_done` → error wins.
  - `dp_done` on the timeout cycle → done wins.
- **ERROR:** sticky. `press` clears `err_code` to 00 and returns to IDLE without starting an operation; a second press is needed.
- **Ignored responses:** `dp_done`/`dp_error` outside WAIT are ignored, including during ISSUE.
- **Ignored presses:** a `press` during ISSUE or WAIT is dropped, not queued.
- **Counter width:** `op_count` is 8 bits and wraps 255→0; it is never cleared except by reset.
- **Timeout counter width:** clog2(`TIMEOUT_CYCLES`+1).

## Timing
- **Reset values:** state IDLE; all outputs 0, including `dp_opcode`=000 and `op_count`=0.
- **Press latency:** `press` asserts 2–3 cycles after the `key_start_n` falling edge; `dp_start` follows in the next cycle.
- **Start to response:** `dp_start` is the cycle after `press`. The first WAIT cycle is the cycle after `dp_start`, and `dp_done` is first honoured in that cycle.
- **Registered outputs:** `busy`, `done_led`, `err_led`, `err_code` and `op_count` are registered. They update in the cycle after the causing edge.
- **Reset mid-operation:** `dp_start` and `busy` drop immediately on `rst_n` assertion; an in-flight datapath result is lost. No press is detected on reset release while the key is held.

## Structure
- **Shared package `op_pkg`:**
  - Opcode constants OP_NONE=000, OP_1..OP_4=001..100.
  - `err_code` constants.
  - State enum.
  - One-hot-to-opcode decode function, also used by the datapath's own checks.
- **Sub-module `key_edge`:** 2-flop synchronizer plus falling-edge detector, 1-bit in, 1-bit `press` out, with `clk`/`rst_n`.
- **Top level:** the FSM, timeout counter and `op_count` live in `op_sequencer`.

## Test plan
- **Reset:** assert `rst_n`=0 mid-WAIT → all outputs 0 in the same cycle; after release with the key held low, no `dp_start` ever.
- **Normal operation:** `sw`=0100, press, `dp_done` 5 cycles after `dp_start` → one `dp_start` pulse with `dp_opcode`=010, `busy` high ISSUE..WAIT, `done_led`=1, `op_count`=1.
- **Invalid switch pattern:** `sw`=0110, press → `err_led`=1, `err_code`=01, no `dp_start`. Second press → `err_code`=00, IDLE. Third press with `sw`=0001 → `dp_opcode`=100.
- **Timeout:** `TIMEOUT_CYCLES`=16, no response → ERROR with `err_code`=10 on the 16th WAIT cycle. Repeat with `dp_done` on that cycle → DONE.
- **Simultaneous responses and dropped press:** `dp_done` and `dp_error` in the same WAIT cycle → `err_code`=11, `op_count` unchanged. A press during WAIT produces no extra `dp_start`.
- **Counter wrap:** 256 back-to-back successful operations → `op_count` wraps to 0. A `dp_done` pulse in IDLE changes nothing.
